// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD requester: FSM state encoding, default width
// and the sizing rule for the optional watchdog counter.
package gcd_pkg;

   localparam int GCD_WIDTH = 32;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ISSUE = 2'd1;
   localparam state_t ST_WAIT  = 2'd2;
   localparam state_t ST_RESP  = 2'd3;

   function automatic int tmo_cnt_w(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/gcd_watchdog.sv
// Cycle counter for the core-launch timeout: counts while run is high, clears
// otherwise, and flags the cycle in which the count reaches TIMEOUT.
module gcd_watchdog
   import gcd_pkg::*;
#(
   parameter int TIMEOUT = 256
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic expired
);

   localparam int CNT_W = tmo_cnt_w(TIMEOUT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = '0;
      if (run) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   // cnt_q is 0 in the launch cycle, so the next value reaches TIMEOUT here
   assign expired = run && (cnt_q == LAST);

endmodule

// File: rtl/gcd_requester.sv
// Host-side initiator for the GCD core; zero operands are answered locally.
// Optional launch timeout is enabled by defining GCD_TIMEOUT_EN.
module gcd_requester
   import gcd_pkg::*;
#(
   parameter int WIDTH   = GCD_WIDTH,
   parameter int TIMEOUT = 256
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             core_start,
   output logic [WIDTH-1:0] core_a,
   output logic [WIDTH-1:0] core_b,
   input  logic             core_done,
   input  logic [WIDTH-1:0] core_c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [WIDTH-1:0] out_gcd,
   output logic             out_err
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] core_a_q, core_a_d;
   logic [WIDTH-1:0] core_b_q, core_b_d;
   logic [WIDTH-1:0] out_a_q, out_a_d;
   logic [WIDTH-1:0] out_b_q, out_b_d;
   logic [WIDTH-1:0] gcd_q, gcd_d;
   logic             err_q, err_d;
   logic             has_zero;
   logic             tmo_expired;

   function automatic logic [WIDTH-1:0] zero_gcd(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
      return (a == '0) ? b : a;
   endfunction

   assign has_zero = (in_a == '0) || (in_b == '0);

`ifdef GCD_TIMEOUT_EN
   gcd_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .run     ((state_q == ST_ISSUE) || (state_q == ST_WAIT)),
      .expired (tmo_expired)
   );
`else
   assign tmo_expired = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (in_valid) state_d = has_zero ? ST_RESP : ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (core_done || tmo_expired) state_d = ST_RESP;
         ST_RESP:  if (out_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready   = 1'b0;
      core_start = 1'b0;
      out_valid  = 1'b0;
      case (state_q)
         ST_IDLE:  in_ready   = 1'b1;
         ST_ISSUE: core_start = 1'b1;
         ST_RESP:  out_valid  = 1'b1;
         default:  ;
      endcase
   end

   always_comb begin
      core_a_d = core_a_q;
      core_b_d = core_b_q;
      out_a_d  = out_a_q;
      out_b_d  = out_b_q;
      gcd_d    = gcd_q;
      err_d    = err_q;
      if ((state_q == ST_IDLE) && in_valid) begin
         out_a_d = in_a;
         out_b_d = in_b;
         err_d   = 1'b0;
         if (has_zero) begin
            gcd_d = zero_gcd(in_a, in_b);
         end else begin
            core_a_d = in_a;
            core_b_d = in_b;
         end
      end else if (state_q == ST_WAIT) begin
         // a done in the expiry cycle still delivers the real result
         if (core_done) begin
            gcd_d = core_c;
            err_d = 1'b0;
         end else if (tmo_expired) begin
            gcd_d = '0;
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         core_a_q <= '0;
         core_b_q <= '0;
         out_a_q  <= '0;
         out_b_q  <= '0;
         gcd_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         core_a_q <= core_a_d;
         core_b_q <= core_b_d;
         out_a_q  <= out_a_d;
         out_b_q  <= out_b_d;
         gcd_q    <= gcd_d;
         err_q    <= err_d;
      end
   end

   assign core_a  = core_a_q;
   assign core_b  = core_b_q;
   assign out_a   = out_a_q;
   assign out_b   = out_b_q;
   assign out_gcd = gcd_q;
   assign out_err = err_q;

endmodule
